// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter.
//   - ALU opcode constants (ALU_Sel encodings)
//   - FSM state enum for the arbiter top
//   - is_legal_op(): 1 when a 4-bit select code is one of the implemented opcodes
package alu_rr_arbiter_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] sel);
    logic legal;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Purely combinational 32-bit ALU.
// Ports:
//   A, B     in  32  operands
//   ALU_Sel  in  4   opcode (see alu_rr_arbiter_pkg)
//   R        out 32  result; 0 for unimplemented opcodes
module alu_rr_arbiter_alu
  import alu_rr_arbiter_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_Sel,
  output logic [31:0] R
);

  always_comb begin
    R = '0;
    case (ALU_Sel)
      ALU_AND: R = A & B;
      ALU_OR:  R = A | B;
      ALU_ADD: R = A + B;
      ALU_SUB: R = A - B;
      ALU_SLT: R = {31'b0, (A < B)};
      ALU_NOR: R = ~(A | B);
      default: R = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one 32-bit ALU between NUM_REQ requesters with round-robin arbitration.
// One operation in flight: operands latched on accept, executed in EXEC, the
// registered result held in RESP until the owner takes it.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (one ready at most)
//   req_a/req_b/req_sel    packed per-requester operands and opcode
//   rsp_valid/rsp_ready    per-requester response handshake (owner bit only)
//   rsp_data, rsp_illegal  shared result and illegal-opcode flag
//   busy                   FSM not in IDLE
//
// state | meaning
// IDLE  | arbitrating; req_ready asserted for the round-robin winner
// EXEC  | latched operands on the ALU; result captured at end of cycle
// RESP  | rsp_valid to owner; wait for owner's rsp_ready
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_sel,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_illegal,
  output logic                     busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_own;
  logic [IDW-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [3:0]         r_op_sel;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [3:0]         w_sel_op;
  logic [WIDTH-1:0]   w_alu_r;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_illegal;
  logic               w_accept;
  logic               w_rsp_hs;

  // One-hot pick of the first valid requester at or above ptr, wrapping.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDW-1:0]     ptr);
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     idx;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  always_comb begin
    w_gnt     = rr_pick(req_valid, r_rr_ptr);
    w_gnt_idx = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx = IDW'(i);
        w_sel_a   = req_a[i*WIDTH +: WIDTH];
        w_sel_b   = req_b[i*WIDTH +: WIDTH];
        w_sel_op  = req_sel[i*4 +: 4];
      end
    end
  end

  // Handshake outputs are gated by rst_n so they read 0 for the whole reset
  // window, including the cycle before the first reset edge.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_rsp_hs  = (r_state == RESP) && rsp_ready[r_own];
  assign busy      = rst_n && (r_state != IDLE);

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = rst_n && (r_state == RESP) && (r_own == IDW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  alu_rr_arbiter_alu u_alu (
    .A       (r_op_a),
    .B       (r_op_b),
    .ALU_Sel (r_op_sel),
    .R       (w_alu_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_own         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_op_sel      <= '0;
      r_rsp_data    <= '0;
      r_rsp_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a        <= w_sel_a;
        r_op_b        <= w_sel_b;
        r_op_sel      <= w_sel_op;
        r_own         <= w_gnt_idx;
        r_rsp_illegal <= ~is_legal_op(w_sel_op);
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_alu_r;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= (r_own == IDW'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;
      end
    end
  end

  assign rsp_data    = r_rsp_data;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;

  alu_rr_arbiter #(.NUM_REQ(2), .WIDTH(32), .IDW(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        ill;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   acyc[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  int   acc_cnt  = 0;
  logic [1:0] prev_ready = 2'b00;
  logic       prev_rsp   = 1'b0;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'b1100: return {1'b0, ~(a | b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard work at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t        e;
    logic [32:0] m;
    @(negedge clk);
    cycle++;
    if (!rst_n) begin
      chk("rst_req_ready", {30'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
    end
    if (|req_ready) begin
      chk("ready_onehot", ($countones(req_ready) == 1) ? 32'd1 : 32'd0, 32'd1);
      chk("ready_pulse", {30'b0, prev_ready}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        m         = model(req_a[i*32 +: 32], req_b[i*32 +: 32], req_sel[i*4 +: 4]);
        e.idx     = i;
        e.data    = m[31:0];
        e.ill     = m[32];
        e.acc_cyc = cycle;
        sb.push_back(e);
        glog.push_back(i);
        acyc.push_back(cycle);
        acc_cnt++;
      end
    end
    if (|rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {30'b0, rsp_valid}, 32'd0);
      end else begin
        e = sb[0];
        if (!prev_rsp) chk("latency", 32'(cycle - e.acc_cyc), 32'd2);
        chk("rsp_owner", {30'b0, rsp_valid}, 32'(1 << e.idx));
        if (rsp_ready[e.idx]) begin
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
          void'(sb.pop_front());
        end
      end
    end
    prev_ready = req_ready;
    prev_rsp   = |rsp_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sel[i*4 +: 4] = s;
  endtask

  task automatic wait_acc();
    int start;
    start = acc_cnt;
    for (int k = 0; k < 20 && acc_cnt == start; k++) cyc();
    chk("accept_timeout", (acc_cnt != start) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) cyc();
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s);
    set_op(i, a, b, s);
    req_valid = 2'(1 << i);
    wait_acc();
    req_valid = 2'b00;
    if (glog.size() > 0) chk("op_grant", glog[$], i);
    chk("busy_exec", {31'b0, busy}, 32'd1);
    wait_drain();
    chk("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  int exp_g[4] = '{0, 1, 0, 1};

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    repeat (3) cyc();
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    cyc();
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Both requesting continuously from reset: grants alternate starting at 0.
    set_op(0, 32'd10, 32'd20, 4'b0010);
    set_op(1, 32'd100, 32'd1, 4'b0110);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    repeat (4) wait_acc();
    req_valid = 2'b00;
    wait_drain();
    for (int k = 0; k < 4; k++) begin
      if (k < glog.size()) chk($sformatf("alt_grant%0d", k), glog[k], exp_g[k]);
      if (k > 0 && k < acyc.size()) chk($sformatf("alt_spacing%0d", k), 32'(acyc[k] - acyc[k-1]), 32'd3);
    end
    chk("alt_count", 32'(glog.size()), 32'd4);

    // Directed operations with rsp_ready held high.
    do_op(0, 32'd5, 32'd3, 4'b0010);
    do_op(1, 32'd5, 32'd3, 4'b0110);
    do_op(1, 32'd0, 32'd1, 4'b0110);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'b0111);
    do_op(0, 32'd1, 32'hFFFF_FFFF, 4'b0111);
    do_op(0, 32'd0, 32'd0, 4'b1100);

    // Illegal opcode, owner stalls while the other requester waits.
    set_op(1, 32'd7, 32'd9, 4'b0011);
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    wait_acc();
    set_op(0, 32'd3, 32'd4, 4'b0001);
    req_valid = 2'b01;
    for (int k = 0; k < 10 && !rsp_valid[1]; k++) cyc();
    chk("ill_rsp_seen", {31'b0, rsp_valid[1]}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("ill_hold_data", rsp_data, 32'd0);
      chk("ill_hold_flag", {31'b0, rsp_illegal}, 32'd1);
      chk("ill_hold_ready", {30'b0, req_ready}, 32'd0);
      chk("ill_hold_valid", {30'b0, rsp_valid}, 32'd2);
      cyc();
    end
    rsp_ready = 2'b11;
    wait_acc();
    req_valid = 2'b00;
    if (glog.size() > 0) chk("waiter_grant", glog[$], 0);
    wait_drain();
    chk("pre_rst_data", rsp_data, 32'd7);

    // Reset while an op is in EXEC: it is dropped and rr_ptr returns to 0.
    set_op(1, 32'd11, 32'd22, 4'b0010);
    req_valid = 2'b10;
    wait_acc();
    chk("rst_inflight_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    req_valid = 2'b11;
    repeat (2) cyc();
    chk("rst_exec_data", rsp_data, 32'd0);
    chk("rst_exec_illegal", {31'b0, rsp_illegal}, 32'd0);
    rst_n = 1'b1;
    wait_acc();
    req_valid = 2'b00;
    if (glog.size() > 0) chk("post_rst_grant", glog[$], 0);
    wait_drain();
    repeat (4) cyc();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
